// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bit counter width; never below one bit so WIDTH=1 still has a terminal count.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the bit slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock, LSB first, through a single full_adder
// with a registered carry loop; done pulses for one cycle when the result is valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             slice_sum;
    logic             slice_carry;
    logic [WIDTH-1:0] res_next;

    full_adder u_slice (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // New sum bit enters at the MSB; written as shifts so WIDTH=1 needs no special slice.
    always_comb begin
        res_next = (res_sr_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_q  <= a_in;
                        b_sr_q  <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_next;
                    carry_q  <= slice_carry;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum_out <= res_next;
                        cout    <= slice_carry;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted start on the 8-bit DUT, then scramble the inputs.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        exp8_q.push_back(9'(a) + 9'(b) + 9'(c));
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    // Bounded wait for done; edges=-1 on timeout.
    task automatic wait_done8(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!done8 && edges < 40) begin
            if (busy8) busy_cycles++;
            tick();
            edges++;
        end
        if (!done8) edges = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy8, done8, cout8, sum8);
        end
        n_checks++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b cout=%b sum=%b, want all 0",
                     busy1, done1, cout1, sum1);
        end
    endtask

    task automatic check_simple(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic c);
        int edges, bcyc;
        logic [8:0] exp;
        tick();
        launch8(a, b, c);
        wait_done8(edges, bcyc);
        n_checks++;
        if (edges !== 8 || bcyc !== 8) begin
            n_fail++;
            $display("FAIL %s_latency: got edges=%0d busy_cycles=%0d, want 8/8", name, edges, bcyc);
        end
        exp = exp8_q.pop_front();
        n_checks++;
        if ({cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got cout=%b sum=%h, want cout=%b sum=%h",
                     name, cout8, sum8, exp[8], exp[7:0]);
        end
        tick();
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: got done=%b busy=%b after done, want 0/0", name, done8, busy8);
        end
    endtask

    task automatic test_zero;
        check_simple("zero", 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_ripple;
        check_simple("ripple", 8'hFF, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back;
        int edges, bcyc;
        logic [8:0] exp, first;
        bit hold_bad;
        tick();
        launch8(8'hA5, 8'h5A, 1'b1);
        wait_done8(edges, bcyc);
        first = exp8_q.pop_front();
        n_checks++;
        if ({cout8, sum8} !== first || first !== 9'h100) begin
            n_fail++;
            $display("FAIL b2b_first: got cout=%b sum=%h, want cout=1 sum=00", cout8, sum8);
        end
        tick();
        launch8(8'h3C, 8'h42, 1'b0);
        hold_bad = 1'b0;
        edges = 0;
        while (!done8 && edges < 40) begin
            if ({cout8, sum8} !== first) hold_bad = 1'b1;
            tick();
            edges++;
        end
        n_checks++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL b2b_hold: result changed before second done, want cout=1 sum=00 held");
        end
        exp = exp8_q.pop_front();
        n_checks++;
        if (!done8 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b cout=%b sum=%h, want done=1 cout=%b sum=%h",
                     done8, cout8, sum8, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_ignore_start;
        int edges, dones;
        logic [8:0] exp;
        tick();
        launch8(8'h10, 8'h20, 1'b0);
        edges = 0;
        while (!done8 && edges < 40) begin
            start8 = (edges == 2);
            a8 = 8'hFF; b8 = 8'hFF;
            tick();
            edges++;
        end
        start8 = 1'b0;
        exp = exp8_q.pop_front();
        n_checks++;
        if (edges !== 8 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL ignore_result: got edges=%0d cout=%b sum=%h, want 8 cout=%b sum=%h",
                     edges, cout8, sum8, exp[8], exp[7:0]);
        end
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        start8 = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (done8 || busy8) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 0 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL ignore_single: got %0d extra busy/done cycles sum=%h, want 0 sum=%h",
                     dones, sum8, exp[7:0]);
        end
    endtask

    task automatic test_reset_mid_run;
        int edges, bcyc, activity;
        logic [8:0] exp;
        tick();
        launch8(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp8_q.delete();
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy8, done8, cout8, sum8);
        end
        activity = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) activity++;
            tick();
        end
        n_checks++;
        if (activity !== 0) begin
            n_fail++;
            $display("FAIL midrun_nodone: got %0d busy/done cycles after abort, want 0", activity);
        end
        launch8(8'h01, 8'h02, 1'b0);
        wait_done8(edges, bcyc);
        exp = exp8_q.pop_front();
        n_checks++;
        if (edges !== 8 || {cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL midrun_restart: got edges=%0d cout=%b sum=%h, want 8 cout=0 sum=03",
                     edges, cout8, sum8);
        end
    endtask

    task automatic test_width1;
        int edges;
        logic [1:0] exp;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            tick();
            start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
            exp1_q.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            tick();
            start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            edges = 0;
            while (!done1 && edges < 10) begin
                tick();
                edges++;
            end
            exp = exp1_q.pop_front();
            n_checks++;
            if (!done1 || edges !== 1 || {cout1, sum1} !== exp) begin
                n_fail++;
                $display("FAIL w1_%0d: got done=%b edges=%0d cout=%b sum=%b, want 1/1 cout=%b sum=%b",
                         i, done1, edges, cout1, sum1, exp[1], exp[0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ripple();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
